// File: rtl/eng_ucq_in_pkg.sv
// eng_ucq_in_pkg: shared literal type, widths and helpers for the unit-clause queue slice
package eng_ucq_in_pkg;
  localparam int LIT_W = 16;
  localparam int NUM_ENGINE = 4;
  typedef logic signed [LIT_W-1:0] lit_t;
  function automatic logic [LIT_W-1:0] lit_var(lit_t lit);
    return lit[LIT_W-1] ? LIT_W'(-lit) : LIT_W'(lit);
  endfunction
endpackage

// File: rtl/eng_ucq_in_lit_match.sv
// ucq_lit_match: parallel duplicate/complement compare of a pushed literal against stored entries
module ucq_lit_match import eng_ucq_in_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  lit_t                          push_lit,
  input  logic [DEPTH-1:0][LIT_W-1:0]   ents,
  input  logic [DEPTH-1:0]              vld,
  output logic                          dup_hit,
  output logic                          comp_hit
);
  lit_t neg_lit;
  assign neg_lit = -push_lit;
  always_comb begin
    dup_hit = 1'b0;
    comp_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dup_hit |= vld[i] && (ents[i] == push_lit);
      comp_hit |= vld[i] && (ents[i] == neg_lit);
    end
  end
endmodule

// File: rtl/eng_ucq_in.sv
// eng_ucq_in: per-engine unit-clause output queue with duplicate/complement filtering.
// Define UCQ_PQ_EN to turn the FIFO into a min-|lit| priority queue.
module eng_ucq_in import eng_ucq_in_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  input  lit_t                     push_lit,
  input  logic                     pop,
  output lit_t                     head_lit,
  output logic                     head_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     conflict,
  output logic                     overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  logic [DEPTH-1:0][LIT_W-1:0] mem;
  logic [DEPTH-1:0] vld;
  logic [IW-1:0] rd_idx, wr_idx;
  logic dup_hit, comp_hit, do_pop, try_push, clean_push, acc, ovf_set;
  ucq_lit_match #(.DEPTH(DEPTH)) u_match (
    .push_lit (push_lit),
    .ents     (mem),
    .vld      (vld),
    .dup_hit  (dup_hit),
    .comp_hit (comp_hit)
  );
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign head_valid = !empty;
  assign head_lit = empty ? '0 : lit_t'(mem[rd_idx]);
  assign do_pop = pop && !empty;
  assign try_push = push_valid && push_lit != '0;
  assign clean_push = try_push && !dup_hit && !comp_hit;
  assign acc = clean_push && (!full || do_pop);
  assign ovf_set = clean_push && full && !do_pop;
`ifdef UCQ_PQ_EN
  logic [IW-1:0] head_idx, free_idx;
  logic [LIT_W-1:0] best;
  always_comb begin
    head_idx = '0;
    best = '1;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && lit_var(mem[i]) < best) begin
        best = lit_var(mem[i]);
        head_idx = IW'(i);
      end
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!vld[i]) free_idx = IW'(i);
  end
  assign rd_idx = head_idx;
  // when full, a concurrent pop frees exactly the head slot for the push
  assign wr_idx = full ? head_idx : free_idx;
`else
  logic [IW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (acc) wr_ptr <= wr_ptr + 1'b1;
    end
  assign rd_idx = rd_ptr;
  assign wr_idx = wr_ptr;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '0;
      vld <= '0;
      count <= '0;
      conflict <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      vld <= '0;
      count <= '0;
      conflict <= 1'b0;
      overflow <= 1'b0;
    end else begin
      conflict <= try_push && comp_hit;
      if (ovf_set) overflow <= 1'b1;
      if (do_pop) vld[rd_idx] <= 1'b0;
      // push after pop so a full push+pop reusing the head slot keeps it valid
      if (acc) begin
        mem[wr_idx] <= push_lit;
        vld[wr_idx] <= 1'b1;
      end
      count <= count + CW'(acc) - CW'(do_pop);
    end
endmodule

// File: tb/tb_eng_ucq_in.sv
// tb_eng_ucq_in: directed self-checking bench for eng_ucq_in (FIFO or UCQ_PQ_EN build)
module tb_eng_ucq_in;
  import eng_ucq_in_pkg::*;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, push_valid = 1'b0, pop = 1'b0;
  lit_t push_lit = '0;
  lit_t head_lit;
  logic head_valid, empty, full, conflict, overflow;
  logic [3:0] count;
  int vecs = 0, errs = 0;
  eng_ucq_in #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_lit(push_lit),
    .pop(pop), .head_lit(head_lit), .head_valid(head_valid), .empty(empty), .full(full),
    .count(count), .conflict(conflict), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic pv, input int lit, input logic pp, input logic fl);
    push_valid = pv;
    push_lit = lit_t'(lit);
    pop = pp;
    flush = fl;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    push_lit = '0;
    pop = 1'b0;
    flush = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_hvalid"}, int'(head_valid), 0);
    chk({tag, "_hlit"}, int'(head_lit), 0);
    chk({tag, "_conflict"}, int'(conflict), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask
  initial begin
    #2;
    chk_reset("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    push_valid = 1'b1;
    push_lit = 16'sd5;
    #1 chk("no_bypass_hvalid", int'(head_valid), 0);
    cyc(1, 5, 0, 0);
    chk("p5_head", int'(head_lit), 5);
    chk("p5_count", int'(count), 1);
    cyc(1, 3, 0, 0);
    cyc(1, -7, 0, 0);
    chk("p3_count", int'(count), 3);
    chk("p3_head", int'(head_lit), 5);
    cyc(0, 0, 1, 0);
    chk("pop1_head", int'(head_lit), 3);
    cyc(0, 0, 1, 0);
    chk("pop2_head", int'(head_lit), -7);
    cyc(0, 0, 1, 0);
    chk("pop3_empty", int'(empty), 1);
    chk("pop3_hlit", int'(head_lit), 0);
    chk("pop3_hvalid", int'(head_valid), 0);
    cyc(1, 4, 0, 0);
    cyc(1, 4, 0, 0);
    chk("dup_count", int'(count), 1);
    chk("dup_conflict", int'(conflict), 0);
    cyc(1, -4, 0, 0);
    chk("comp_conflict", int'(conflict), 1);
    chk("comp_count", int'(count), 1);
    cyc(0, 0, 0, 0);
    chk("comp_pulse_end", int'(conflict), 0);
    cyc(0, 0, 0, 1);
    chk("flush_count", int'(count), 0);
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    chk("fill_ovf", int'(overflow), 0);
    cyc(1, 9, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_full", int'(full), 1);
    chk("ovf_head", int'(head_lit), 1);
    cyc(1, 9, 1, 0);
    chk("fullpp_head", int'(head_lit), 2);
    chk("fullpp_count", int'(count), 8);
    chk("ovf_sticky", int'(overflow), 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
    chk("tail_head", int'(head_lit), 9);
    chk("tail_count", int'(count), 1);
    cyc(0, 0, 0, 1);
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_empty", int'(empty), 1);
    cyc(1, 6, 1, 0);
    chk("popempty_head", int'(head_lit), 6);
    chk("popempty_count", int'(count), 1);
    cyc(1, 0, 0, 0);
    chk("nullpush_count", int'(count), 1);
    cyc(0, 0, 0, 1);
    cyc(1, 3, 0, 0);
    cyc(1, 5, 0, 0);
    cyc(1, 3, 1, 0);
    chk("duppop_count", int'(count), 1);
    chk("duppop_head", int'(head_lit), 5);
    cyc(1, 3, 0, 0);
    chk("refill_count", int'(count), 2);
    cyc(1, 7, 1, 1);
    chk("flushpp_count", int'(count), 0);
    chk("flushpp_empty", int'(empty), 1);
    chk("flushpp_ovf", int'(overflow), 0);
    cyc(0, 0, 0, 0);
    chk("flushpp_nostore", int'(head_valid), 0);
    cyc(1, 9, 0, 0);
    cyc(1, -2, 0, 0);
    cyc(1, 5, 0, 0);
`ifdef UCQ_PQ_EN
    chk("pq_head0", int'(head_lit), -2);
    cyc(0, 0, 1, 0);
    chk("pq_head1", int'(head_lit), 5);
    cyc(0, 0, 1, 0);
    chk("pq_head2", int'(head_lit), 9);
`else
    chk("fifo_head0", int'(head_lit), 9);
    cyc(0, 0, 1, 0);
    chk("fifo_head1", int'(head_lit), -2);
    cyc(0, 0, 1, 0);
    chk("fifo_head2", int'(head_lit), 5);
`endif
    cyc(1, -11, 0, 0);
    cyc(1, 12, 0, 0);
    chk("pre_arst_count", int'(count), 3);
    #2 rst = 1'b0;
    #1 chk_reset("arst");
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("post_arst_count", int'(count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
